// File: rtl/latency_absorber_pkg.sv
// Shared constants and width helpers for the latency absorber.
package latency_absorber_pkg;

  localparam int unsigned ERR_OVF = 0;
  localparam int unsigned ERR_UNF = 1;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // One extra bit so the counters can hold the value DEPTH itself.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/latency_absorber_if.sv
// Request, pipe-return and result handshake bundle of the latency absorber.
interface latency_absorber_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             req_valid;
  logic             req_ready;
  logic             pipe_issue;
  logic             pipe_ret_valid;
  logic [WIDTH-1:0] pipe_ret_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [1:0]       err;

  modport master (
    output req_valid, pipe_ret_valid, pipe_ret_data, m_ready,
    input  req_ready, pipe_issue, m_valid, m_data, err
  );

  modport slave (
    input  req_valid, pipe_ret_valid, pipe_ret_data, m_ready,
    output req_ready, pipe_issue, m_valid, m_data, err
  );

endinterface

// File: rtl/latency_absorber_ram.sv
// Return buffer storage: one synchronous write port, one asynchronous read port.
module absorb_ram
  import latency_absorber_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/latency_absorber.sv
// Credit-based return buffer for a fixed-latency, non-stallable pipe.
// Define LATENCY_ABSORBER_ERR_EN to build sticky overflow/underflow detection.
module latency_absorber
  import latency_absorber_pkg::*;
#(
  parameter int unsigned LATENCY = 5,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                clk,
  input  logic                rst,
  latency_absorber_if.slave   bus
);

  localparam int unsigned PtrW = ptr_w(DEPTH);
  localparam int unsigned CntW = cnt_w(DEPTH);
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
  localparam logic [CntW-1:0] OneC   = CntW'(1);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

  if (LATENCY < 1 || DEPTH < LATENCY + 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("latency_absorber: DEPTH must be a power of two and >= LATENCY+2, LATENCY >= 1");
  end

  logic [CntW-1:0] credits_q, credits_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic            issue, pop, we;

  assign bus.req_ready  = !rst && (credits_q != '0);
  assign issue          = bus.req_valid && bus.req_ready;
  assign bus.pipe_issue = issue;
  assign bus.m_valid    = (count_q != '0);
  assign pop            = bus.m_valid && bus.m_ready;

`ifdef LATENCY_ABSORBER_ERR_EN
  logic          ovf, unf;
  logic [CntW:0] committed;
  logic [1:0]    err_q;

  // Nothing is in flight when every credit is either free or parked in the buffer.
  assign committed = {1'b0, credits_q} + {1'b0, count_q};
  assign ovf       = bus.pipe_ret_valid && (count_q == DepthC) && !pop;
  assign unf       = bus.pipe_ret_valid && (committed >= {1'b0, DepthC});
  assign we        = bus.pipe_ret_valid && !ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 2'b00;
    end else begin
      if (ovf) err_q[ERR_OVF] <= 1'b1;
      if (unf) err_q[ERR_UNF] <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign we      = bus.pipe_ret_valid;
  assign bus.err = 2'b00;
`endif

  always_comb begin
    credits_d = credits_q;
    if (issue && !pop) begin
      credits_d = credits_q - OneC;
    end else if (pop && !issue && credits_q != DepthC) begin
      // Saturate so a stray return can never mint credits beyond DEPTH.
      credits_d = credits_q + OneC;
    end

    count_d = count_q;
    if (we && !pop) begin
      count_d = count_q + OneC;
    end else if (pop && !we) begin
      count_d = count_q - OneC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q <= DepthC;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      credits_q <= credits_d;
      count_q   <= count_d;
      if (we)  wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop) rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  absorb_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (bus.pipe_ret_data),
    .raddr (rd_ptr_q),
    .rdata (bus.m_data)
  );

endmodule

// File: tb/tb_latency_absorber.sv
// Directed bench for latency_absorber with a fixed-latency pipe model.
// Error-injection steps follow LATENCY_ABSORBER_ERR_EN.
module tb_latency_absorber;

  localparam int unsigned LATENCY = 5;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned DEPTH   = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  latency_absorber_if #(.WIDTH(WIDTH)) bus ();

  latency_absorber #(
    .LATENCY (LATENCY),
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Pipe model: returns the issue index exactly LATENCY cycles after issue.
  logic [LATENCY:1] sr_v;
  logic [WIDTH-1:0] sr_d [LATENCY+1];
  logic [WIDTH-1:0] idx;
  logic             inj_v;
  logic [WIDTH-1:0] inj_d;

  always @(posedge clk) begin
    if (rst) begin
      sr_v <= '0;
      idx  <= '0;
    end else begin
      sr_v    <= {sr_v[LATENCY-1:1], bus.pipe_issue};
      sr_d[1] <= idx;
      for (int k = 2; k <= LATENCY; k++) sr_d[k] <= sr_d[k-1];
      if (bus.pipe_issue) idx <= idx + 1'b1;
    end
  end

  assign bus.pipe_ret_valid = sr_v[LATENCY] | inj_v;
  assign bus.pipe_ret_data  = inj_v ? inj_d : sr_d[LATENCY];

  int vectors     = 0;
  int miscompares = 0;
  int n_iss;
  int exp_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b1;
    bus.m_ready   = 1'b0;
    inj_v         = 1'b0;
    inj_d         = '0;

    // Reset: req_valid high must not leak into pipe_issue.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_issue", 32'(bus.pipe_issue), 0);
    check("rst_m_valid", 32'(bus.m_valid), 0);
    check("rst_err", 32'(bus.err), 0);
    next_cycle();
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 32'(bus.req_ready), 1);

    // Streaming: 20 back-to-back issues, results 0..19 starting 6 cycles later.
    for (int c = 0; c < 30; c++) begin
      next_cycle();
      bus.req_valid = (c < 20);
      bus.m_ready   = 1'b1;
      @(negedge clk);
      check("stream_issue", 32'(bus.pipe_issue), 32'(c < 20));
      if (c < 20) check("stream_req_ready", 32'(bus.req_ready), 1);
      check("stream_m_valid", 32'(bus.m_valid), 32'(c >= 6 && c < 26));
      if (c >= 6 && c < 26) check("stream_data", 32'(bus.m_data), 32'(c - 6));
    end

    // Stall fill: exactly DEPTH issues, then credits run out.
    for (int s = 0; s < 20; s++) begin
      next_cycle();
      bus.req_valid = 1'b1;
      bus.m_ready   = 1'b0;
      @(negedge clk);
      check("fill_issue", 32'(bus.pipe_issue), 32'(s < 8));
    end
    check("fill_req_ready", 32'(bus.req_ready), 0);
    check("fill_m_valid", 32'(bus.m_valid), 1);
    check("fill_head", 32'(bus.m_data), 20);

    // Drain: credit from a pop is usable only the following cycle.
    for (int d = 0; d < 10; d++) begin
      next_cycle();
      bus.req_valid = 1'b0;
      bus.m_ready   = 1'b1;
      @(negedge clk);
      check("drain_req_ready", 32'(bus.req_ready), 32'(d >= 1));
      check("drain_m_valid", 32'(bus.m_valid), 32'(d < 8));
      if (d < 8) check("drain_data", 32'(bus.m_data), 32'(20 + d));
    end

    // Fill again, then pop and issue together every cycle.
    for (int f = 0; f < 15; f++) begin
      next_cycle();
      bus.req_valid = 1'b1;
      bus.m_ready   = 1'b0;
      @(negedge clk);
      check("sim_fill_issue", 32'(bus.pipe_issue), 32'(f < 8));
    end
    for (int k = 0; k < 12; k++) begin
      next_cycle();
      bus.req_valid = 1'b1;
      bus.m_ready   = 1'b1;
      @(negedge clk);
      check("sim_req_ready", 32'(bus.req_ready), 32'(k >= 1));
      check("sim_issue", 32'(bus.pipe_issue), 32'(k >= 1));
      check("sim_m_valid", 32'(bus.m_valid), 1);
      check("sim_data", 32'(bus.m_data), 32'(28 + k));
      check("sim_err", 32'(bus.err), 0);
    end
    for (int d = 0; d < 12; d++) begin
      next_cycle();
      bus.req_valid = 1'b0;
      bus.m_ready   = 1'b1;
    end
    @(negedge clk);
    check("sim_empty", 32'(bus.m_valid), 0);

    // Reset with 3 requests in flight and 2 results buffered.
    for (int r = 0; r < 7; r++) begin
      next_cycle();
      bus.req_valid = (r < 5);
      bus.m_ready   = 1'b0;
    end
    next_cycle();
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_req_ready", 32'(bus.req_ready), 0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("mid_m_valid", 32'(bus.m_valid), 0);
    check("mid_req_ready", 32'(bus.req_ready), 1);
    check("mid_err", 32'(bus.err), 0);
    for (int q = 0; q < 8; q++) begin
      next_cycle();
      @(negedge clk);
      check("mid_quiet", 32'(bus.m_valid), 0);
    end
    // Credits must be back to DEPTH: exactly 8 issues fit.
    for (int f = 0; f < 15; f++) begin
      next_cycle();
      bus.req_valid = 1'b1;
      bus.m_ready   = 1'b0;
      @(negedge clk);
      check("mid_fill_issue", 32'(bus.pipe_issue), 32'(f < 8));
    end
    for (int d = 0; d < 10; d++) begin
      next_cycle();
      bus.req_valid = 1'b0;
      bus.m_ready   = 1'b1;
      @(negedge clk);
      check("mid_drain_m_valid", 32'(bus.m_valid), 32'(d < 8));
      if (d < 8) check("mid_drain_data", 32'(bus.m_data), 32'(d));
    end

`ifdef LATENCY_ABSORBER_ERR_EN
    // Return with nothing in flight: underflow, data still written.
    next_cycle();
    bus.m_ready = 1'b0;
    inj_v       = 1'b1;
    inj_d       = 8'hA5;
    @(negedge clk);
    check("unf_err_before", 32'(bus.err), 0);
    next_cycle();
    inj_v = 1'b0;
    @(negedge clk);
    check("unf_err", 32'(bus.err), 32'h2);
    check("unf_m_valid", 32'(bus.m_valid), 1);
    check("unf_data", 32'(bus.m_data), 32'hA5);
    next_cycle();
    bus.m_ready = 1'b1;
    next_cycle();
    bus.m_ready = 1'b0;
    @(negedge clk);
    check("unf_sticky", 32'(bus.err), 32'h2);
    check("unf_popped", 32'(bus.m_valid), 0);

    // Return into a full buffer with no pop: overflow, data dropped.
    for (int f = 0; f < 15; f++) begin
      next_cycle();
      bus.req_valid = 1'b1;
      @(negedge clk);
      check("ovf_fill_issue", 32'(bus.pipe_issue), 32'(f < 8));
    end
    next_cycle();
    bus.req_valid = 1'b0;
    inj_v         = 1'b1;
    inj_d         = 8'hC3;
    next_cycle();
    inj_v = 1'b0;
    @(negedge clk);
    check("ovf_err", 32'(bus.err), 32'h3);
    check("ovf_head", 32'(bus.m_data), 8);
    for (int d = 0; d < 10; d++) begin
      next_cycle();
      bus.m_ready = 1'b1;
      @(negedge clk);
      check("ovf_drain_m_valid", 32'(bus.m_valid), 32'(d < 8));
      if (d < 8) check("ovf_drain_data", 32'(bus.m_data), 32'(8 + d));
    end
    check("ovf_sticky", 32'(bus.err), 32'h3);
`else
    // Detection not built: a stray return must leave err at zero.
    next_cycle();
    bus.m_ready = 1'b0;
    inj_v       = 1'b1;
    inj_d       = 8'hA5;
    next_cycle();
    inj_v = 1'b0;
    @(negedge clk);
    check("noerr_err", 32'(bus.err), 0);
    next_cycle();
    bus.m_ready = 1'b1;
    next_cycle();
    @(negedge clk);
    check("noerr_err_after", 32'(bus.err), 0);
`endif

    // Wrap-around: 3*DEPTH results under random backpressure.
    next_cycle();
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.m_ready   = 1'b0;
    next_cycle();
    rst   = 1'b0;
    n_iss = 0;
    exp_d = 0;
    for (int w = 0; w < 400 && exp_d < 3 * DEPTH; w++) begin
      next_cycle();
      bus.req_valid = (n_iss < 3 * DEPTH);
      bus.m_ready   = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.pipe_issue) n_iss++;
      if (bus.m_valid && bus.m_ready) begin
        check("wrap_data", 32'(bus.m_data), 32'(exp_d));
        exp_d++;
      end
    end
    check("wrap_results", 32'(exp_d), 3 * DEPTH);
    check("wrap_issues", 32'(n_iss), 3 * DEPTH);
    check("wrap_err", 32'(bus.err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
